motor_drive: RTL and testbench
==============================

// Module: motor_drive
// PURPOSE
//  Downstream stage of dig_core: consumes the signed 11-bit wheel commands lft/rht
//  and the go enable, and drives the H-bridge direction/PWM pins for both motors.
//  Commands are double-buffered and applied only at PWM period boundaries.
//  A dead-time interval is inserted on every direction reversal, so fwd and rev are
//  never both high.
// PARAMETERS
//  PWM_BITS      10  PWM counter width; period = 2**PWM_BITS clk cycles
//  DEAD_PERIODS  2   full PWM periods of coast inserted on a direction reversal
// PORTS
//  clk       in   1   system clock (single clock domain)
//  rst_n     in   1   asynchronous active-low reset
//  go        in   1   motion enable from dig_core
//  lft       in   11  signed two's-complement left wheel command
//  rht       in   11  signed two's-complement right wheel command
//  fwd_lft   out  1   left motor forward PWM
//  rev_lft   out  1   left motor reverse PWM
//  fwd_rht   out  1   right motor forward PWM
//  rev_rht   out  1   right motor reverse PWM
//  prd_strt  out  1   one-cycle pulse, high in the cycle the counter reads 0
// BEHAVIOUR
//  - Reset: cnt=0, all four PWM outputs 0, prd_strt 0, shadow magnitudes 0,
//    last_dir=FWD, channel state COAST, dead counter 0.
//  - cnt: free-running PWM_BITS-bit counter, 0..1023 wrapping to 0; it never stops,
//    including while go=0.
//  - Sample point, cnt==0: if go=1, each channel latches mag=|cmd| and sgn=cmd[10].
//    If go=0, it latches mag=0.
//  - Magnitude width rule: |cmd| saturates to 10 bits, so -1024 gives mag=1023.
//    +1023 and -1023 both give 1023. A cmd of 0 gives mag=0.
//  - Per-channel FSM, evaluated at cnt==0:
//      COAST: mag==0. Outputs low; last_dir is unchanged.
//      FWD / REV: mag!=0 and sgn matches last_dir. Drive the selected pin; the other
//        pin stays low.
//      DEAD: mag!=0 and sgn differs from last_dir. Outputs low for DEAD_PERIODS
//        periods, then last_dir<=sgn, enter FWD/REV and apply the current shadow mag.
//      Leaving DEAD: a new sample of mag==0 moves to COAST. A new sample of opposite
//        sign back to last_dir aborts DEAD straight to the old direction.
//      A reversal through an intermediate COAST still incurs DEAD, because last_dir
//        is remembered.
//  - Duty: the driven pin is registered high while cnt < mag.
//      mag=0 -> constant low.
//      mag=512 -> 512 high cycles per 1024.
//      mag=1023 -> low for exactly 1 cycle per period.
//  - Latency: outputs are registered; a compare at cnt=k appears on the pin at cycle
//    k+1. prd_strt is aligned with the cycle cnt==0.
//  - go falling mid-period: all PWM outputs go low on the next clk edge. The FSM and
//    last_dir are held. go rising mid-period has no effect until the next cnt==0.
//  - Commands that change mid-period are ignored until the next cnt==0 (no glitching).
//  - Invariant: fwd_x & rev_x == 0 in every cycle, including the reset edge.
//  - Asynchronous reset mid-period forces all outputs to 0 immediately and restarts
//    the period from cnt=0.
// STRUCTURE
//  - motor_pkg:
//      localparam PWM_BITS, DEAD_PERIODS defaults
//      typedef enum logic [1:0] {COAST, FWD, REV, DEAD} mtr_state_t
//      typedef logic dir_t (0=FWD, 1=REV)
//      function abs_sat11to10
//  - Sub-module mtr_chnl: one per wheel, instantiated twice. Contains the shadow
//    registers, FSM, dead counter and output compare.
//  - Top level holds the shared cnt, prd_strt and go gating.
// TESTING
//  1. Reset, then go=1, lft=+512, rht=+256 -> after the first prd_strt,
//     fwd_lft high 512/1024 cycles and fwd_rht high 256/1024; rev_* stay 0.
//  2. Set lft=+300 then -300 mid-period -> fwd_lft finishes the current period at 300;
//     both lft pins are low for 2 periods; then rev_lft is high 300/1024.
//  3. Set lft=-1024 and rht=0 -> rev_lft is low exactly 1 cycle per period;
//     rht pins are constant 0 and no DEAD is entered.
//  4. Run at lft=+800 and drop go at cnt=100 -> fwd_lft is 0 from cycle 101 on.
//     Raise go at cnt=500 -> fwd_lft stays 0 until the next cnt==0, then resumes at 800.
//  5. Set rht=+400, then 0 for 1 period, then -400 -> rht coasts, then DEAD for
//     2 periods, then rev_rht at 400.
//  6. Assert rst_n=0 at cnt=700 while driving -> all outputs are 0 asynchronously.
//     After release, cnt restarts at 0. An assertion checks fwd&rev==0 on every
//     cycle of every test.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types, default parameters and command-magnitude helper for the
// H-bridge motor drive.
package motor_pkg;

    localparam int unsigned PWM_BITS     = 10;
    localparam int unsigned DEAD_PERIODS = 2;
    localparam int unsigned CMD_W        = 11;
    localparam int unsigned MAG_W        = 10;

    typedef enum logic [1:0] {COAST, FWD, REV, DEAD} mtr_state_t;

    typedef logic dir_t;
    localparam dir_t DIR_FWD = 1'b0;
    localparam dir_t DIR_REV = 1'b1;

    // |cmd| clipped to 10 bits; only -1024 overflows and maps to 1023
    function automatic logic [MAG_W-1:0] abs_sat11to10(input logic [CMD_W-1:0] cmd);
        logic [CMD_W-1:0] mag;
        mag = cmd[CMD_W-1] ? CMD_W'(-cmd) : cmd;
        if (mag[CMD_W-1]) begin
            return '1;
        end
        return mag[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/motor_drive_chnl.sv
// One wheel channel: period-sampled shadow magnitude, direction FSM with
// dead-time on reversal, and the registered PWM compare.
module mtr_chnl #(
    parameter int unsigned PWM_BITS     = motor_pkg::PWM_BITS,
    parameter int unsigned DEAD_PERIODS = motor_pkg::DEAD_PERIODS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_i,
    input  logic                        en_i,
    input  logic [PWM_BITS-1:0]         cnt_i,
    input  logic [motor_pkg::CMD_W-1:0] cmd_i,
    output logic                        fwd_o,
    output logic                        rev_o
);
    import motor_pkg::*;

    localparam int unsigned DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

    mtr_state_t        state_q, state_d;
    logic [MAG_W-1:0]  mag_q, mag_d;
    dir_t              last_dir_q, last_dir_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              fwd_q, fwd_d;
    logic              rev_q, rev_d;
    dir_t              new_dir;
    logic              on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COAST;
            mag_q      <= '0;
            last_dir_q <= DIR_FWD;
            dead_q     <= '0;
            fwd_q      <= 1'b0;
            rev_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            last_dir_q <= last_dir_d;
            dead_q     <= dead_d;
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
        end
    end

    // State and shadow only move at the period boundary
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        last_dir_d = last_dir_q;
        dead_d     = dead_q;
        new_dir    = cmd_i[CMD_W-1];
        if (sample_i) begin
            mag_d  = en_i ? abs_sat11to10(cmd_i) : '0;
            dead_d = '0;
            if (mag_d == '0) begin
                state_d = COAST;
            end else if (new_dir == last_dir_q) begin
                state_d = (last_dir_q == DIR_REV) ? REV : FWD;
            end else if (state_q != DEAD) begin
                state_d = DEAD;
            end else if (dead_q == DEAD_LAST) begin
                state_d    = (new_dir == DIR_REV) ? REV : FWD;
                last_dir_d = new_dir;
            end else begin
                dead_d = dead_q + DEAD_W'(1);
            end
        end
        on    = en_i && (cnt_i < PWM_BITS'(mag_d));
        fwd_d = on && (state_d == FWD);
        rev_d = on && (state_d == REV);
    end

    assign fwd_o = fwd_q;
    assign rev_o = rev_q;

endmodule

// File: rtl/motor_drive.sv
// Dual H-bridge PWM driver: shared period counter, period-start pulse and
// go gating around two wheel channels.
module motor_drive #(
    parameter int unsigned PWM_BITS     = motor_pkg::PWM_BITS,
    parameter int unsigned DEAD_PERIODS = motor_pkg::DEAD_PERIODS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        go,
    input  logic [motor_pkg::CMD_W-1:0] lft,
    input  logic [motor_pkg::CMD_W-1:0] rht,
    output logic                        fwd_lft,
    output logic                        rev_lft,
    output logic                        fwd_rht,
    output logic                        rev_rht,
    output logic                        prd_strt
);
    import motor_pkg::*;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                prd_q, prd_d;
    logic                go_en_q, go_en_d;
    logic                sample_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            prd_q   <= 1'b0;
            go_en_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            prd_q   <= prd_d;
            go_en_q <= go_en_d;
        end
    end

    // go may kill drive at any edge but can only re-arm it at a period start
    always_comb begin
        sample_c = (cnt_q == '0);
        cnt_d    = cnt_q + PWM_BITS'(1);
        prd_d    = &cnt_q;
        go_en_d  = sample_c ? go : (go_en_q & go);
    end

    mtr_chnl #(
        .PWM_BITS     (PWM_BITS),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_lft (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i (sample_c),
        .en_i     (go_en_d),
        .cnt_i    (cnt_q),
        .cmd_i    (lft),
        .fwd_o    (fwd_lft),
        .rev_o    (rev_lft)
    );

    mtr_chnl #(
        .PWM_BITS     (PWM_BITS),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_rht (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i (sample_c),
        .en_i     (go_en_d),
        .cnt_i    (cnt_q),
        .cmd_i    (rht),
        .fwd_o    (fwd_rht),
        .rev_o    (rev_rht)
    );

    assign prd_strt = prd_q;

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive: one table row per PWM period, comparing
// high-cycle counts of each pin, plus reset sequences.
module tb_motor_drive;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic [10:0] lft;
    logic [10:0] rht;
    logic        fwd_lft, rev_lft, fwd_rht, rev_rht, prd_strt;

    int passed = 0;
    int total  = 0;

    localparam int NONE = 1024;

    typedef struct {
        int lft; int rht; bit go;
        int c1;  int l1;  int r1; bit g1;
        int c2;  bit g2;
        int efl; int erl; int efr; int err;
    } vec_t;

    vec_t vecs[26];

    motor_drive dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .lft      (lft),
        .rht      (rht),
        .fwd_lft  (fwd_lft),
        .rev_lft  (rev_lft),
        .fwd_rht  (fwd_rht),
        .rev_rht  (rev_rht),
        .prd_strt (prd_strt)
    );

    always #5 clk = ~clk;

    a_excl: assert property (@(negedge clk) !(fwd_lft && rev_lft) && !(fwd_rht && rev_rht))
        else $error("FAIL excl: fwd_lft=%b rev_lft=%b fwd_rht=%b rev_rht=%b, required no pair both 1",
                    fwd_lft, rev_lft, fwd_rht, rev_rht);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s [%0d]: got %0d, required %0d", name, idx, act, exp);
    endtask

    function automatic vec_t mk(input int l, input int r, input bit g,
                                input int c1, input int l1, input int r1, input bit g1,
                                input int c2, input bit g2,
                                input int efl, input int erl, input int efr, input int err);
        vec_t v;
        v.lft = l;  v.rht = r;  v.go = g;
        v.c1 = c1;  v.l1 = l1;  v.r1 = r1; v.g1 = g1;
        v.c2 = c2;  v.g2 = g2;
        v.efl = efl; v.erl = erl; v.efr = efr; v.err = err;
        return v;
    endfunction

    // Entered at the negedge of a cnt==0 cycle; leaves at the next one
    task automatic run_period(input vec_t v, output int cfl, output int crl,
                              output int cfr, output int crr, output int prd_bad,
                              output int both);
        cfl = 0; crl = 0; cfr = 0; crr = 0; prd_bad = 0; both = 0;
        lft = 11'(v.lft); rht = 11'(v.rht); go = v.go;
        for (int i = 0; i < 1024; i++) begin
            if (i == v.c1) begin
                lft = 11'(v.l1); rht = 11'(v.r1); go = v.g1;
            end
            if (i == v.c2) go = v.g2;
            cfl += int'(fwd_lft); crl += int'(rev_lft);
            cfr += int'(fwd_rht); crr += int'(rev_rht);
            if (prd_strt != (i == 0)) prd_bad++;
            if ((fwd_lft && rev_lft) || (fwd_rht && rev_rht)) both++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, cfl, crl, cfr, crr, prd_bad, both, first_prd;

        //             lft   rht  go  c1    l1    r1  g1  c2    g2  fl   rl    fr    rr
        vecs[0]  = mk( 512,  256, 1, NONE,    0,    0, 1, NONE, 1, 512,   0,  256,    0);
        vecs[1]  = mk( 300,  256, 1,  500, -300,  256, 1, NONE, 1, 300,   0,  256,    0);
        vecs[2]  = mk(-300,  256, 1, NONE,    0,    0, 1, NONE, 1,   0,   0,  256,    0);
        vecs[3]  = mk(-300,  256, 1, NONE,    0,    0, 1, NONE, 1,   0,   0,  256,    0);
        vecs[4]  = mk(-300,  256, 1, NONE,    0,    0, 1, NONE, 1,   0, 300,  256,    0);
        vecs[5]  = mk(-1024,   0, 1, NONE,    0,    0, 1, NONE, 1,   0, 1023,   0,    0);
        vecs[6]  = mk(-1023, 1023,1, NONE,    0,    0, 1, NONE, 1,   0, 1023, 1023,   0);
        vecs[7]  = mk( 800,  400, 1, NONE,    0,    0, 1, NONE, 1,   0,   0,  400,    0);
        vecs[8]  = mk( 800,  400, 1, NONE,    0,    0, 1, NONE, 1,   0,   0,  400,    0);
        vecs[9]  = mk( 800,  400, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,  400,    0);
        vecs[10] = mk( 800,  400, 1,  100,  800,  400, 0,  500, 1, 100,   0,  100,    0);
        vecs[11] = mk( 800,  400, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,  400,    0);
        vecs[12] = mk( 800,    0, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,    0,    0);
        vecs[13] = mk( 800, -400, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,    0,    0);
        vecs[14] = mk( 800, -400, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,    0,    0);
        vecs[15] = mk( 800, -400, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,    0,  400);
        vecs[16] = mk(-800, -400, 1, NONE,    0,    0, 1, NONE, 1,   0,   0,    0,  400);
        vecs[17] = mk( 800, -400, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,    0,  400);
        vecs[18] = mk( 800, -400, 0, NONE,    0,    0, 0, NONE, 0,   0,   0,    0,    0);
        vecs[19] = mk( 800, -400, 1, NONE,    0,    0, 1, NONE, 1, 800,   0,    0,  400);
        vecs[20] = mk(   1,   -1, 1, NONE,    0,    0, 1, NONE, 1,   1,   0,    0,    1);
        vecs[21] = mk( 512,   -1, 1,  300,  100, -700, 1, NONE, 1, 512,   0,    0,    1);
        vecs[22] = mk( 100, -700, 1, NONE,    0,    0, 1, NONE, 1, 100,   0,    0,  700);
        vecs[23] = mk(-100, -700, 1, NONE,    0,    0, 1, NONE, 1,   0,   0,    0,  700);
        vecs[24] = mk(   0, -700, 1, NONE,    0,    0, 1, NONE, 1,   0,   0,    0,  700);
        vecs[25] = mk( 100, -700, 1, NONE,    0,    0, 1, NONE, 1, 100,   0,    0,  700);

        rst_n = 1'b0; go = 1'b0; lft = '0; rht = '0;
        repeat (2) @(negedge clk);
        chk("reset_fwd_lft", 0, int'(fwd_lft), 0);
        chk("reset_rev_lft", 0, int'(rev_lft), 0);
        chk("reset_fwd_rht", 0, int'(fwd_rht), 0);
        chk("reset_rev_rht", 0, int'(rev_rht), 0);
        chk("reset_prd_strt", 0, int'(prd_strt), 0);
        rst_n = 1'b1;

        n = 0;
        while (!prd_strt && n < 2100) begin
            @(negedge clk);
            n++;
        end
        chk("first_prd_strt_cycle", 0, n, 1024);
        if (!prd_strt) begin
            $display("FAIL sync: prd_strt never rose, got 0, required 1");
            $display("%0d/%0d checks passed", passed, total + 1);
            $fatal(1);
        end

        foreach (vecs[k]) begin
            run_period(vecs[k], cfl, crl, cfr, crr, prd_bad, both);
            chk("fwd_lft_high", k, cfl, vecs[k].efl);
            chk("rev_lft_high", k, crl, vecs[k].erl);
            chk("fwd_rht_high", k, cfr, vecs[k].efr);
            chk("rev_rht_high", k, crr, vecs[k].err);
            chk("prd_strt_bad_cycles", k, prd_bad, 0);
            chk("overlap_cycles", k, both, 0);
        end

        // Asynchronous reset while driving, then period restart
        lft = 11'(800); rht = '0; go = 1'b1;
        repeat (700) @(negedge clk);
        chk("drive_at_700", 0, int'(fwd_lft), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", 0,
               int'({fwd_lft, rev_lft, fwd_rht, rev_rht, prd_strt}), 0);
        @(negedge clk);
        chk("held_reset_outs", 0,
            int'({fwd_lft, rev_lft, fwd_rht, rev_rht, prd_strt}), 0);
        rst_n = 1'b1;
        first_prd = 0; cfl = 0; crl = 0;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk);
            if (prd_strt && first_prd == 0) first_prd = i;
            if (i < 1024) begin
                cfl += int'(fwd_lft);
                crl += int'(rev_lft);
            end
        end
        chk("restart_prd_cycle", 0, first_prd, 1024);
        chk("restart_fwd_lft_high", 0, cfl, 800);
        chk("restart_rev_lft_high", 0, crl, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
